// File: rtl/alu_issue_scheduler.sv
// ----------------------------------------------------------------------------
// alu_issue_scheduler
//
// Issue-select controller for the ALU reservation station. It tracks which
// RS entries are occupied and how old each one is. Every cycle it picks the
// two oldest operand-ready entries and grants them to ALU0/ALU1, provided
// those units can accept an instruction.
//
// Ports
//   clk          : clock, all state updates on posedge
//   reset        : synchronous active-high reset
//   flush        : squash, clears occupancy, ages and pending grants
//   alloc_valid  : bit k = dispatch lane k writes entry alloc_idx<k>
//   alloc_idx0/1 : slot index written by dispatch lane 0/1
//   entry_ready  : bit i = both source operands of entry i are ready
//   alu_rdy      : bit k = ALUk accepts an instruction this cycle
//   grant_valid  : bit k = grant_idx<k> issued to ALUk (registered pulse)
//   grant_idx0/1 : entry issued to ALU0/ALU1 (zero when not granted)
//   occupied     : registered occupancy mask
//   issue_count  : number of grants asserted, registered with grant_valid
// ----------------------------------------------------------------------------
module alu_issue_scheduler #(
    parameter int RS_DEPTH = 8,
    parameter int IDX_W    = 3,
    parameter int AGE_W    = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic [1:0]          alloc_valid,
    input  logic [IDX_W-1:0]    alloc_idx0,
    input  logic [IDX_W-1:0]    alloc_idx1,
    input  logic [RS_DEPTH-1:0] entry_ready,
    input  logic [1:0]          alu_rdy,
    output logic [1:0]          grant_valid,
    output logic [IDX_W-1:0]    grant_idx0,
    output logic [IDX_W-1:0]    grant_idx1,
    output logic [RS_DEPTH-1:0] occupied,
    output logic [1:0]          issue_count
);

    // Saturating add of the per-cycle allocation count onto an age counter.
    // The sum cannot exceed twice the counter range, so a carry out of the
    // top bit is the only overflow indication needed.
    function automatic logic [AGE_W-1:0] age_sat_add(input logic [AGE_W-1:0] age,
                                                     input logic [1:0]       inc);
        logic [AGE_W:0] sum;
        sum = {1'b0, age} + (AGE_W+1)'(inc);
        if (sum[AGE_W]) begin
            return {AGE_W{1'b1}};
        end else begin
            return sum[AGE_W-1:0];
        end
    endfunction

    logic [RS_DEPTH-1:0] occupied_q, occupied_d;
    logic [AGE_W-1:0]    age_q [RS_DEPTH];
    logic [AGE_W-1:0]    age_d [RS_DEPTH];
    logic [1:0]          grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0]    grant_idx0_q, grant_idx0_d;
    logic [IDX_W-1:0]    grant_idx1_q, grant_idx1_d;
    logic [1:0]          issue_count_q, issue_count_d;

    logic [RS_DEPTH-1:0] cand_s;
    logic                first_vld_s, second_vld_s;
    logic [IDX_W-1:0]    first_idx_s, second_idx_s;
    logic [AGE_W-1:0]    first_age_s, second_age_s;
    logic                alloc0_en_s, alloc1_en_s;
    logic [1:0]          num_alloc_s;
    logic [RS_DEPTH-1:0] free_mask_s;
    logic [RS_DEPTH-1:0] alloc_mask_s;

    // Oldest ready entry; strict '>' keeps the lowest index on an age tie.
    always_comb begin
        cand_s      = occupied_q & entry_ready;
        first_vld_s = 1'b0;
        first_idx_s = {IDX_W{1'b0}};
        first_age_s = {AGE_W{1'b0}};
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand_s[i] && (!first_vld_s || (age_q[i] > first_age_s))) begin
                first_vld_s = 1'b1;
                first_idx_s = IDX_W'(i);
                first_age_s = age_q[i];
            end else begin
                first_vld_s = first_vld_s;
            end
        end
    end

    // Second-oldest ready entry, excluding the first pick.
    always_comb begin
        second_vld_s = 1'b0;
        second_idx_s = {IDX_W{1'b0}};
        second_age_s = {AGE_W{1'b0}};
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand_s[i] && !(first_vld_s && (first_idx_s == IDX_W'(i))) &&
                (!second_vld_s || (age_q[i] > second_age_s))) begin
                second_vld_s = 1'b1;
                second_idx_s = IDX_W'(i);
                second_age_s = age_q[i];
            end else begin
                second_vld_s = second_vld_s;
            end
        end
    end

    // Map picks onto ALU lanes; a lone ready ALU always gets the oldest pick.
    always_comb begin
        grant_valid_d = 2'b00;
        grant_idx0_d  = {IDX_W{1'b0}};
        grant_idx1_d  = {IDX_W{1'b0}};
        if (!flush) begin
            case (alu_rdy)
                2'b11: begin
                    grant_valid_d = {second_vld_s, first_vld_s};
                    grant_idx0_d  = first_vld_s  ? first_idx_s  : {IDX_W{1'b0}};
                    grant_idx1_d  = second_vld_s ? second_idx_s : {IDX_W{1'b0}};
                end
                2'b10: begin
                    grant_valid_d = {first_vld_s, 1'b0};
                    grant_idx1_d  = first_vld_s ? first_idx_s : {IDX_W{1'b0}};
                end
                2'b01: begin
                    grant_valid_d = {1'b0, first_vld_s};
                    grant_idx0_d  = first_vld_s ? first_idx_s : {IDX_W{1'b0}};
                end
                default: begin
                    grant_valid_d = 2'b00;
                end
            endcase
        end else begin
            grant_valid_d = 2'b00;
        end
        issue_count_d = {1'b0, grant_valid_d[0]} + {1'b0, grant_valid_d[1]};
    end

    // Allocation decode; a duplicate index on lane 1 is dropped entirely.
    always_comb begin
        alloc0_en_s  = alloc_valid[0];
        alloc1_en_s  = alloc_valid[1] && !(alloc_valid[0] && (alloc_idx0 == alloc_idx1));
        num_alloc_s  = {1'b0, alloc0_en_s} + {1'b0, alloc1_en_s};
        alloc_mask_s = {RS_DEPTH{1'b0}};
        free_mask_s  = {RS_DEPTH{1'b0}};
        if (alloc0_en_s) begin
            alloc_mask_s[alloc_idx0] = 1'b1;
        end else begin
            alloc_mask_s = alloc_mask_s;
        end
        if (alloc1_en_s) begin
            alloc_mask_s[alloc_idx1] = 1'b1;
        end else begin
            alloc_mask_s = alloc_mask_s;
        end
        if (grant_valid_d[0]) begin
            free_mask_s[grant_idx0_d] = 1'b1;
        end else begin
            free_mask_s = free_mask_s;
        end
        if (grant_valid_d[1]) begin
            free_mask_s[grant_idx1_d] = 1'b1;
        end else begin
            free_mask_s = free_mask_s;
        end
    end

    // Occupancy and age next state; alloc overrides a same-cycle free.
    always_comb begin
        occupied_d = (occupied_q & ~free_mask_s) | alloc_mask_s;
        for (int i = 0; i < RS_DEPTH; i++) begin
            age_d[i] = age_q[i];
            if (flush) begin
                age_d[i] = {AGE_W{1'b0}};
            end else if (alloc0_en_s && (alloc_idx0 == IDX_W'(i))) begin
                // Lane 0 is older than lane 1 when both dispatch together.
                age_d[i] = alloc1_en_s ? AGE_W'(1) : {AGE_W{1'b0}};
            end else if (alloc1_en_s && (alloc_idx1 == IDX_W'(i))) begin
                age_d[i] = {AGE_W{1'b0}};
            end else if (occupied_q[i] && !free_mask_s[i]) begin
                age_d[i] = age_sat_add(age_q[i], num_alloc_s);
            end else begin
                age_d[i] = age_q[i];
            end
        end
        if (flush) begin
            occupied_d = {RS_DEPTH{1'b0}};
        end else begin
            occupied_d = occupied_d;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            occupied_q    <= {RS_DEPTH{1'b0}};
            grant_valid_q <= 2'b00;
            grant_idx0_q  <= {IDX_W{1'b0}};
            grant_idx1_q  <= {IDX_W{1'b0}};
            issue_count_q <= 2'b00;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= {AGE_W{1'b0}};
            end
        end else begin
            occupied_q    <= occupied_d;
            grant_valid_q <= grant_valid_d;
            grant_idx0_q  <= grant_idx0_d;
            grant_idx1_q  <= grant_idx1_d;
            issue_count_q <= issue_count_d;
            for (int i = 0; i < RS_DEPTH; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

    assign occupied    = occupied_q;
    assign grant_valid = grant_valid_q;
    assign grant_idx0  = grant_idx0_q;
    assign grant_idx1  = grant_idx1_q;
    assign issue_count = issue_count_q;

endmodule
